// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, types and round helper functions
//
// Purpose: shared definitions for the SHA-256 block engine.
//   word_t      32-bit SHA-256 word
//   state_e     engine control states (IDLE, RUN, FINAL, DONE)
//   K           64 round constants
//   H0          initial hash value, word a in [255:224]
//   big_sigma0/1, small_sigma0/1, ch, maj, add_state
// No ports (package).
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise mod-2^32 sum of two packed 8-word states (no carry between words).
  function automatic logic [255:0] add_state(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) begin
      r[255-32*j -: 32] = x[255-32*j -: 32] + y[255-32*j -: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_block_engine_if.sv
// rtl/sha256_block_engine_if.sv - block input / digest output handshake bundle
//
// Purpose: groups the block-in and digest-out valid/ready channels.
//   in_valid / in_ready / in_first / M_in  : 512-bit block offer, word 0 in [511:480]
//   out_valid / out_ready / H_out          : 256-bit digest, a in [255:224]
//   busy                                   : engine occupied
// Modports: master = block producer / digest consumer, slave = engine.
interface sha256_block_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [511:0] M_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] H_out;
  logic         busy;

  modport master (
    output in_valid, in_first, M_in, out_ready,
    input  in_ready, out_valid, H_out, busy
  );

  modport slave (
    input  in_valid, in_first, M_in, out_ready,
    output in_ready, out_valid, H_out, busy
  );
endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
//
// Purpose: applies a single round to the working variables.
// Ports:
//   a..h                 in   current working variables
//   k                    in   round constant K[t]
//   w                    in   schedule word W[t]
//   a_next..h_next       out  working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  input  word_t e,
  input  word_t f,
  input  word_t g,
  input  word_t h,
  input  word_t k,
  input  word_t w,
  output word_t a_next,
  output word_t b_next,
  output word_t c_next,
  output word_t d_next,
  output word_t e_next,
  output word_t f_next,
  output word_t g_next,
  output word_t h_next
);
  word_t t1;
  word_t t2;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;
endmodule

// File: rtl/sha256_block_engine.sv
// rtl/sha256_block_engine.sv - SHA-256 compression engine, UNROLL rounds per clock
//
// Purpose: compresses one pre-padded 512-bit block per transaction and chains
// the resulting digest into the next block when in_first is low.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of sha256_block_engine_if (block in, digest out, busy)
// Parameter UNROLL: rounds per clock, one of 1, 2, 4, 8.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha256_block_engine_if.slave bus
);
  localparam int CYC = 64 / UNROLL;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FINAL = ST_FINAL;
  localparam logic [1:0] S_DONE  = ST_DONE;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_block_engine: UNROLL must be 1, 2, 4 or 8");
  end

  logic [1:0]   state;
  logic [5:0]   ctr;
  logic [511:0] wwin;    // W[t..t+15], W[t] in [511:480]
  logic [255:0] work;    // a..h, a in [255:224]
  logic [255:0] base;    // hash value the current block started from
  logic [255:0] chain;   // digest handed to the next in_first=0 block
  logic [255:0] h_out_r;
  logic [255:0] rounds_out;

  // Slides the schedule window forward by UNROLL words. With UNROLL > 2 the
  // later new words depend on earlier new words (W[t-2]), so they are built in
  // order in an extended scratch array.
  function automatic logic [511:0] next_window(input logic [511:0] w);
    word_t        ext [0:23];
    logic [511:0] r;
    for (int j = 0; j < 16; j++) begin
      ext[j] = w[511-32*j -: 32];
    end
    for (int j = 0; j < UNROLL; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
    for (int j = 16 + UNROLL; j < 24; j++) begin
      ext[j] = '0;
    end
    for (int j = 0; j < 16; j++) begin
      r[511-32*j -: 32] = ext[UNROLL+j];
    end
    return r;
  endfunction

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    logic [5:0]   k_idx;

    assign k_idx = ctr * 6'(UNROLL) + 6'(i);

    if (i == 0) begin : g_head
      assign st_in = work;
    end else begin : g_link
      assign st_in = g_rnd[i-1].st_out;
    end

    sha256_round u_round (
      .a      (st_in[255:224]),
      .b      (st_in[223:192]),
      .c      (st_in[191:160]),
      .d      (st_in[159:128]),
      .e      (st_in[127:96]),
      .f      (st_in[95:64]),
      .g      (st_in[63:32]),
      .h      (st_in[31:0]),
      .k      (K[k_idx]),
      .w      (wwin[511-32*i -: 32]),
      .a_next (st_out[255:224]),
      .b_next (st_out[223:192]),
      .c_next (st_out[191:160]),
      .d_next (st_out[159:128]),
      .e_next (st_out[127:96]),
      .f_next (st_out[95:64]),
      .g_next (st_out[63:32]),
      .h_next (st_out[31:0])
    );
  end

  assign rounds_out = g_rnd[UNROLL-1].st_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ctr     <= '0;
      wwin    <= '0;
      work    <= '0;
      base    <= '0;
      chain   <= H0;
      h_out_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            wwin  <= bus.M_in;
            work  <= bus.in_first ? H0 : chain;
            base  <= bus.in_first ? H0 : chain;
            ctr   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          work <= rounds_out;
          wwin <= next_window(wwin);
          ctr  <= ctr + 6'd1;
          if (ctr == 6'(CYC - 1)) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          h_out_r <= add_state(base, work);
          chain   <= add_state(base, work);
          state   <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.H_out     = h_out_r;
endmodule

// File: tb/tb_sha256_block_engine.sv
// tb/tb_sha256_block_engine.sv - scoreboard bench for sha256_block_engine (UNROLL 1, 4, 8)
module tb_sha256_block_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_block_engine_if bus1 ();
  sha256_block_engine_if bus4 ();
  sha256_block_engine_if bus8 ();

  sha256_block_engine #(.UNROLL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  sha256_block_engine #(.UNROLL(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  sha256_block_engine #(.UNROLL(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_2B = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_2A = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] D_2B = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  int           sel;
  logic         in_valid;
  logic         in_first;
  logic         out_ready;
  logic [511:0] M_in;
  logic         obs_in_ready;
  logic         obs_out_valid;
  logic         obs_busy;
  logic [255:0] obs_h;

  // Only the selected engine sees stimulus; the idle ones always drain.
  always_comb begin
    bus1.in_valid  = in_valid && (sel == 0);
    bus4.in_valid  = in_valid && (sel == 1);
    bus8.in_valid  = in_valid && (sel == 2);
    bus1.in_first  = in_first;
    bus4.in_first  = in_first;
    bus8.in_first  = in_first;
    bus1.M_in      = M_in;
    bus4.M_in      = M_in;
    bus8.M_in      = M_in;
    bus1.out_ready = (sel == 0) ? out_ready : 1'b1;
    bus4.out_ready = (sel == 1) ? out_ready : 1'b1;
    bus8.out_ready = (sel == 2) ? out_ready : 1'b1;
    case (sel)
      1: begin
        obs_in_ready = bus4.in_ready; obs_out_valid = bus4.out_valid;
        obs_busy = bus4.busy; obs_h = bus4.H_out;
      end
      2: begin
        obs_in_ready = bus8.in_ready; obs_out_valid = bus8.out_valid;
        obs_busy = bus8.busy; obs_h = bus8.H_out;
      end
      default: begin
        obs_in_ready = bus1.in_ready; obs_out_valid = bus1.out_valid;
        obs_busy = bus1.busy; obs_h = bus1.H_out;
      end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_q [$];
  int           lat_q [$];
  int           acc_cyc;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers one block to the selected engine; on acceptance the expected digest
  // and latency are queued when the block is meant to complete.
  task automatic send(input logic [511:0] m, input logic first, input logic [255:0] exp,
                      input int lat, input bit expect_out);
    int n = 0;
    @(negedge clk);
    M_in = m; in_first = first; in_valid = 1'b1;
    while (!obs_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 256'(obs_in_ready), 256'(1));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (expect_out) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'($urandom);
    M_in = {16{$urandom}};
    check("busy_run", 256'(obs_busy), 256'(1));
    check("in_ready_run", 256'(obs_in_ready), 256'(0));
  endtask

  // Waits for the digest, pops the scoreboard and compares digest and latency.
  task automatic collect(input string tag);
    int           n = 0;
    logic [255:0] e;
    int           l;
    while (!obs_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 256'(obs_out_valid), 256'(1));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 256'(0), 256'(1));
    end else begin
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check({tag, "_digest"}, obs_h, e);
      check({tag, "_latency"}, 256'(cyc - acc_cyc), 256'(l));
      if (out_ready) begin
        @(negedge clk);
        check({tag, "_in_ready_after"}, 256'(obs_in_ready), 256'(1));
        check({tag, "_out_valid_after"}, 256'(obs_out_valid), 256'(0));
        check({tag, "_h_retained"}, obs_h, e);
      end
    end
  endtask

  initial begin
    bit saw;
    sel = 0; in_valid = 1'b0; in_first = 1'b0; M_in = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(obs_in_ready), 256'(1));
    check("rst_out_valid", 256'(obs_out_valid), 256'(0));
    check("rst_busy", 256'(obs_busy), 256'(0));
    check("rst_h_out", obs_h, 256'(0));
    rst_n = 1'b1;

    send(BLK_ABC, 1'b1, D_ABC, 65, 1'b1);
    collect("abc_u1");
    send(BLK_EMPTY, 1'b1, D_EMPTY, 65, 1'b1);
    collect("empty_u1");

    // First block of the two-block message under output backpressure.
    out_ready = 1'b0;
    send(BLK_2A, 1'b1, D_2A, 65, 1'b1);
    collect("two_a_u1");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_first = 1'b1; M_in = {16{$urandom}};
      @(negedge clk);
      check("bp_out_valid", 256'(obs_out_valid), 256'(1));
      check("bp_in_ready", 256'(obs_in_ready), 256'(0));
      check("bp_h_stable", obs_h, D_2A);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 256'(obs_in_ready), 256'(1));
    check("bp_release_out_valid", 256'(obs_out_valid), 256'(0));
    send(BLK_2B, 1'b0, D_2B, 65, 1'b1);
    collect("two_b_u1");

    // Abort a block at round 30; chain must revert to H0.
    send(BLK_ABC, 1'b1, '0, 0, 1'b0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 256'(obs_in_ready), 256'(1));
    check("mid_rst_out_valid", 256'(obs_out_valid), 256'(0));
    check("mid_rst_busy", 256'(obs_busy), 256'(0));
    check("mid_rst_h_out", obs_h, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (obs_out_valid) saw = 1'b1;
    end
    check("abort_no_out_valid", 256'(saw), 256'(0));
    send(BLK_ABC, 1'b0, D_ABC, 65, 1'b1);
    collect("abc_chain_h0_u1");

    sel = 1;
    send(BLK_ABC, 1'b1, D_ABC, 17, 1'b1);
    collect("abc_u4");

    sel = 2;
    send(BLK_ABC, 1'b1, D_ABC, 9, 1'b1);
    collect("abc_u8");
    send(BLK_2A, 1'b1, D_2A, 9, 1'b1);
    collect("two_a_u8");
    send(BLK_2B, 1'b0, D_2B, 9, 1'b1);
    collect("two_b_u8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
